// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared fetch constants, bubble word and per-cycle action encoding.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_WORD   = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_REDIRECT,
        ACT_WAIT,
        ACT_FETCH
    } fetch_act_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id.sv
// if_id_reg: IF/ID pipeline register with hold and bubble-insert controls.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hold,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    // A bubble clears instr/valid but leaves pc4 alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_instr <= i_bubble ? NOP_INSTR : i_instr;
            r_pc4   <= i_bubble ? r_pc4 : i_pc4;
            r_valid <= !i_bubble;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC ownership, instruction fetch and IF/ID register feeding decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] r_pc;
    logic [31:0] r_count;
    logic [31:0] w_pc4;
    fetch_act_e  w_act;

    always_comb begin
        w_act = stall       ? ACT_HOLD     :
                redirect    ? ACT_REDIRECT :
                !imem_ready ? ACT_WAIT     : ACT_FETCH;
    end

    assign w_pc4 = r_pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= word_align(RESET_PC);
            r_count <= 32'h0;
        end else begin
            r_pc    <= (w_act == ACT_REDIRECT) ? word_align(redirect_pc) :
                       (w_act == ACT_FETCH)    ? w_pc4 : r_pc;
            r_count <= (w_act == ACT_FETCH) ? r_count + 32'h1 : r_count;
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (w_act == ACT_HOLD),
        .i_bubble (w_act != ACT_FETCH),
        .i_instr  (imem_rdata),
        .i_pc4    (w_pc4),
        .o_instr  (id_instr),
        .o_pc4    (id_pc4),
        .o_valid  (id_valid)
    );

    assign imem_addr   = r_pc;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus random traffic checked against a behavioural fetch model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [31:0] fetch_count;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pc4 = 32'h0, m_count = 32'h0;
    logic        m_valid = 1'b0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : ((a ^ 32'hA5A5_0000) * 32'h0001_0DCD) + 32'h1;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the decode stage must see after one rising edge, from the priority rules.
    task automatic model_edge();
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
        end else if (stall) begin
        end else if (redirect) begin
            m_instr = 32'h0; m_valid = 1'b0;
            m_pc = redirect_pc & ~32'h3;
        end else if (!imem_ready) begin
            m_instr = 32'h0; m_valid = 1'b0;
        end else begin
            m_instr = mem_word(m_pc);
            m_pc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            m_count = m_count + 32'd1;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc, input logic rdy);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc; imem_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("id_instr", id_instr, m_instr);
        chk("id_pc4", id_pc4, m_pc4);
        chk("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
        chk("fetch_count", fetch_count, m_count);
    endtask

    initial begin
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        step(0, 0, 0, 0, 1);
        chk("t1_instr", id_instr, 32'h2008_0005);
        chk("t1_pc4", id_pc4, 32'h4);
        chk("t1_addr", imem_addr, 32'h4);
        step(0, 0, 0, 0, 1);
        repeat (3) step(0, 1, 0, 0, 1);
        chk("t2_addr", imem_addr, 32'h8);
        chk("t2_count", fetch_count, 32'h2);
        chk("t2_pc4", id_pc4, 32'h8);
        step(0, 0, 0, 0, 1);
        chk("t2_resume", imem_addr, 32'hC);
        step(0, 0, 1, 32'h0000_0043, 1);
        chk("t3_addr", imem_addr, 32'h40);
        chk("t3_valid", {31'h0, id_valid}, 32'h0);
        chk("t3_instr", id_instr, 32'h0);
        chk("t3_count", fetch_count, 32'h3);
        step(0, 1, 1, 32'h0000_0100, 1);
        chk("t4_hold", imem_addr, 32'h40);
        step(0, 0, 1, 32'h0000_0010, 1);
        chk("t4_redir", imem_addr, 32'h10);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t5_addr", imem_addr, 32'h10);
        chk("t5_count", fetch_count, 32'h3);
        step(0, 0, 0, 0, 1);
        chk("t5_pc4", id_pc4, 32'h14);
        step(0, 0, 1, 32'hFFFF_FFFE, 1);
        chk("t6_align", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1);
        chk("t6_wrap_pc", imem_addr, 32'h0);
        chk("t6_wrap_pc4", id_pc4, 32'h0);
        step(0, 1, 0, 0, 1);
        step(1, 1, 1, 32'h0000_0200, 0);
        chk("t6_rst_pc", imem_addr, 32'h0);
        chk("t6_rst_valid", {31'h0, id_valid}, 32'h0);
        chk("t6_rst_count", fetch_count, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 12, rpc, $urandom_range(0, 99) < 75);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
